// File: rtl/skin_blob_stats.sv
// rtl/skin_blob_stats.sv - per-frame skin bounding box and hit count behind the median filter
// Optional blob centroid via two sequential restoring dividers: define CENTROID_EN.
module skin_blob_stats #(
   parameter int H_SIZE    = 83,
   parameter int V_SIZE    = 83,
   parameter int THRESH    = 128,
   parameter int MIN_COUNT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [7:0]  pixel_in,
   output logic [6:0]  x_min,
   output logic [6:0]  x_max,
   output logic [6:0]  y_min,
   output logic [6:0]  y_max,
   output logic [12:0] hit_count,
   output logic        blob_found,
   output logic [6:0]  cx,
   output logic [6:0]  cy,
   output logic        result_valid
);
   localparam logic [6:0]  X_LAST = 7'(H_SIZE - 1);
   localparam logic [6:0]  Y_LAST = 7'(V_SIZE - 1);
   localparam logic [7:0]  THR    = 8'(THRESH);
   localparam logic [12:0] MINC   = 13'(MIN_COUNT);

`ifdef CENTROID_EN
   typedef enum logic [1:0] {WAIT_SYNC, ACCUM, DIVIDE} state_t;
`else
   typedef enum logic [1:0] {WAIT_SYNC, ACCUM} state_t;
`endif

   state_t      state_q, state_d;
   logic        vsync_q, vsync_d, de_q, de_d;
   logic [6:0]  x_q, x_d, y_q, y_d;
   logic [12:0] acc_cnt_q, acc_cnt_d;
   logic [6:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
   logic [6:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
   logic [6:0]  x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
   logic [12:0] hit_count_q, hit_count_d;
   logic        found_q, found_d, rv_q, rv_d;
   logic        vs_rise, de_fall, hit, pub;
   logic [6:0]  y_eff, pub_xmin, pub_xmax, pub_ymin, pub_ymax;
   logic [12:0] pub_cnt;
   logic        unused_hsync;

   assign unused_hsync = hsync_in;

`ifdef CENTROID_EN
   logic [19:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d, quo_x_q, quo_x_d, quo_y_q, quo_y_d;
   logic [12:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d, den_q, den_d;
   logic [4:0]  div_cnt_q, div_cnt_d;
   logic [6:0]  pend_xmin_q, pend_xmin_d, pend_xmax_q, pend_xmax_d;
   logic [6:0]  pend_ymin_q, pend_ymin_d, pend_ymax_q, pend_ymax_d;
   logic [6:0]  cx_q, cx_d, cy_q, cy_d, pub_cx, pub_cy;

   // One restoring-division bit: shift dividend MSB into remainder, subtract if it fits.
   function automatic logic [32:0] div_step(input logic [12:0] rem, input logic [19:0] quo,
                                            input logic [12:0] den);
      logic [13:0] r;
      logic [19:0] q;
      r = {rem, quo[19]};
      q = {quo[18:0], 1'b0};
      if (r >= {1'b0, den}) begin
         r    = r - {1'b0, den};
         q[0] = 1'b1;
      end
      return {r[12:0], q};
   endfunction

   assign cx = cx_q;
   assign cy = cy_q;
`else
   assign cx = '0;
   assign cy = '0;
`endif

   always_comb begin
      vs_rise = ce && vsync_in && !vsync_q;
      de_fall = ce && !de_in && de_q;
      // A pixel coinciding with the frame-end edge is the first pixel of the new frame.
      y_eff   = vs_rise ? '0 : y_q;
      hit     = ce && de_in && (pixel_in >= THR) && ((state_q != WAIT_SYNC) || vs_rise);

      state_d = state_q;
      vsync_d = ce ? vsync_in : vsync_q;
      de_d    = ce ? de_in : de_q;
      x_d = x_q;  y_d = y_q;
      acc_cnt_d = acc_cnt_q;
      acc_xmin_d = acc_xmin_q;  acc_xmax_d = acc_xmax_q;
      acc_ymin_d = acc_ymin_q;  acc_ymax_d = acc_ymax_q;
      x_min_d = x_min_q;  x_max_d = x_max_q;  y_min_d = y_min_q;  y_max_d = y_max_q;
      hit_count_d = hit_count_q;  found_d = found_q;
      pub = 1'b0;
      pub_cnt = acc_cnt_q;
      pub_xmin = acc_xmin_q;  pub_xmax = acc_xmax_q;
      pub_ymin = acc_ymin_q;  pub_ymax = acc_ymax_q;
`ifdef CENTROID_EN
      sum_x_d = sum_x_q;  sum_y_d = sum_y_q;
      quo_x_d = quo_x_q;  quo_y_d = quo_y_q;
      rem_x_d = rem_x_q;  rem_y_d = rem_y_q;
      den_d = den_q;  div_cnt_d = div_cnt_q;
      pend_xmin_d = pend_xmin_q;  pend_xmax_d = pend_xmax_q;
      pend_ymin_d = pend_ymin_q;  pend_ymax_d = pend_ymax_q;
      cx_d = cx_q;  cy_d = cy_q;
      pub_cx = '0;  pub_cy = '0;
`endif

      if (ce) begin
         if (de_in) x_d = (x_q == X_LAST) ? x_q : x_q + 7'd1;
         else if (de_q) x_d = '0;
         if (vs_rise) y_d = '0;
         else if (de_fall && (y_q != Y_LAST)) y_d = y_q + 7'd1;
      end

      if (vs_rise) begin
         acc_cnt_d = '0;
         acc_xmin_d = 7'h7F;  acc_xmax_d = '0;
         acc_ymin_d = 7'h7F;  acc_ymax_d = '0;
`ifdef CENTROID_EN
         sum_x_d = '0;  sum_y_d = '0;
`endif
      end
      if (hit) begin
         if (acc_cnt_d != 13'h1FFF) acc_cnt_d = acc_cnt_d + 13'd1;
         if (x_q < acc_xmin_d) acc_xmin_d = x_q;
         if (x_q > acc_xmax_d) acc_xmax_d = x_q;
         if (y_eff < acc_ymin_d) acc_ymin_d = y_eff;
         if (y_eff > acc_ymax_d) acc_ymax_d = y_eff;
`ifdef CENTROID_EN
         sum_x_d = sum_x_d + 20'(x_q);
         sum_y_d = sum_y_d + 20'(y_eff);
`endif
      end

      case (state_q)
         WAIT_SYNC: if (vs_rise) state_d = ACCUM;
         default: begin
`ifdef CENTROID_EN
            if (vs_rise) begin
               if (acc_cnt_q == '0) begin
                  pub = 1'b1;
                  state_d = ACCUM;
               end else begin
                  state_d = DIVIDE;
                  quo_x_d = sum_x_q;  quo_y_d = sum_y_q;
                  rem_x_d = '0;  rem_y_d = '0;
                  den_d = acc_cnt_q;  div_cnt_d = '0;
                  pend_xmin_d = acc_xmin_q;  pend_xmax_d = acc_xmax_q;
                  pend_ymin_d = acc_ymin_q;  pend_ymax_d = acc_ymax_q;
               end
            end else if ((state_q == DIVIDE) && ce) begin
               {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, den_q);
               {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, den_q);
               div_cnt_d = div_cnt_q + 5'd1;
               if (div_cnt_q == 5'd19) begin
                  pub = 1'b1;
                  state_d = ACCUM;
                  pub_cnt = den_q;
                  pub_xmin = pend_xmin_q;  pub_xmax = pend_xmax_q;
                  pub_ymin = pend_ymin_q;  pub_ymax = pend_ymax_q;
                  pub_cx = quo_x_d[6:0];  pub_cy = quo_y_d[6:0];
               end
            end
`else
            pub = vs_rise;
`endif
         end
      endcase

      if (pub) begin
         x_min_d = (pub_cnt != '0) ? pub_xmin : '0;
         x_max_d = (pub_cnt != '0) ? pub_xmax : '0;
         y_min_d = (pub_cnt != '0) ? pub_ymin : '0;
         y_max_d = (pub_cnt != '0) ? pub_ymax : '0;
         hit_count_d = pub_cnt;
         found_d = (pub_cnt >= MINC);
`ifdef CENTROID_EN
         cx_d = pub_cx;  cy_d = pub_cy;
`endif
      end
      rv_d = pub;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_SYNC;  vsync_q <= 1'b0;  de_q <= 1'b0;
         x_q <= '0;  y_q <= '0;  acc_cnt_q <= '0;
         acc_xmin_q <= 7'h7F;  acc_xmax_q <= '0;  acc_ymin_q <= 7'h7F;  acc_ymax_q <= '0;
         x_min_q <= '0;  x_max_q <= '0;  y_min_q <= '0;  y_max_q <= '0;
         hit_count_q <= '0;  found_q <= 1'b0;  rv_q <= 1'b0;
`ifdef CENTROID_EN
         sum_x_q <= '0;  sum_y_q <= '0;  quo_x_q <= '0;  quo_y_q <= '0;
         rem_x_q <= '0;  rem_y_q <= '0;  den_q <= '0;  div_cnt_q <= '0;
         pend_xmin_q <= '0;  pend_xmax_q <= '0;  pend_ymin_q <= '0;  pend_ymax_q <= '0;
         cx_q <= '0;  cy_q <= '0;
`endif
      end else begin
         state_q <= state_d;  vsync_q <= vsync_d;  de_q <= de_d;
         x_q <= x_d;  y_q <= y_d;  acc_cnt_q <= acc_cnt_d;
         acc_xmin_q <= acc_xmin_d;  acc_xmax_q <= acc_xmax_d;
         acc_ymin_q <= acc_ymin_d;  acc_ymax_q <= acc_ymax_d;
         x_min_q <= x_min_d;  x_max_q <= x_max_d;  y_min_q <= y_min_d;  y_max_q <= y_max_d;
         hit_count_q <= hit_count_d;  found_q <= found_d;  rv_q <= rv_d;
`ifdef CENTROID_EN
         sum_x_q <= sum_x_d;  sum_y_q <= sum_y_d;  quo_x_q <= quo_x_d;  quo_y_q <= quo_y_d;
         rem_x_q <= rem_x_d;  rem_y_q <= rem_y_d;  den_q <= den_d;  div_cnt_q <= div_cnt_d;
         pend_xmin_q <= pend_xmin_d;  pend_xmax_q <= pend_xmax_d;
         pend_ymin_q <= pend_ymin_d;  pend_ymax_q <= pend_ymax_d;
         cx_q <= cx_d;  cy_q <= cy_d;
`endif
      end
   end

   assign x_min = x_min_q;
   assign x_max = x_max_q;
   assign y_min = y_min_q;
   assign y_max = y_max_q;
   assign hit_count = hit_count_q;
   assign blob_found = found_q;
   assign result_valid = rv_q;
endmodule

// File: tb/tb_skin_blob_stats.sv
// tb/tb_skin_blob_stats.sv - table-driven and randomized frame checks for skin_blob_stats
// Build with CENTROID_EN defined to also check cx/cy, divider latency and abort.
module tb_skin_blob_stats;
   logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
   logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [7:0]  pixel_in = 8'd0;
   logic [6:0]  x_min, x_max, y_min, y_max, cx, cy;
   logic [12:0] hit_count;
   logic        blob_found, result_valid;

   always #5 clk = ~clk;

   skin_blob_stats dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .de_in(de_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .pixel_in(pixel_in), .x_min(x_min), .x_max(x_max),
      .y_min(y_min), .y_max(y_max), .hit_count(hit_count), .blob_found(blob_found),
      .cx(cx), .cy(cy), .result_valid(result_valid)
   );

   typedef struct { int xmin, xmax, ymin, ymax, cnt, found, cx, cy; } res_t;
   typedef struct { int x0, x1, y0, y1, val, bg, nl, cemode; res_t exp; } vec_t;

   logic [7:0] img [0:82][0:82];
   int ce_mode = 0;
   int n_total = 0, n_bad = 0, exp_results = 0;
   int rv_count = 0, width_bad = 0;
   logic rv_prev = 1'b0;

   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         rv_count <= rv_count + 1;
         if (rv_prev) width_bad <= width_bad + 1;
      end
      rv_prev <= (result_valid === 1'b1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One ce=1 cycle; in gap modes a ce=0 cycle with junk inputs precedes it.
   task automatic cyc(input logic de, input logic vs, input logic [7:0] px);
      if (ce_mode == 1 || (ce_mode == 2 && $urandom_range(0, 2) == 0)) begin
         ce = 1'b0;  de_in = 1'($urandom);  vsync_in = 1'($urandom);
         pixel_in = 8'($urandom);
         @(posedge clk); #1;
      end
      ce = 1'b1;  de_in = de;  vsync_in = vs;  hsync_in = !de;  pixel_in = px;
      @(posedge clk); #1;
   endtask

   task automatic send_lines(input int nl);
      for (int y = 0; y < nl; y++) begin
         for (int x = 0; x < 83; x++) cyc(1'b1, 1'b0, img[y][x]);
         cyc(1'b0, 1'b0, 8'd0);
      end
   endtask

   task automatic fill_rect(input int x0, x1, y0, y1, input logic [7:0] val, bg);
      for (int y = 0; y < 83; y++)
         for (int x = 0; x < 83; x++)
            img[y][x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? val : bg;
   endtask

   task automatic fill_random();
      int rx0, rx1, ry0, ry1;
      rx0 = $urandom_range(0, 82);  rx1 = $urandom_range(rx0, 82);
      ry0 = $urandom_range(0, 82);  ry1 = $urandom_range(ry0, 82);
      for (int y = 0; y < 83; y++)
         for (int x = 0; x < 83; x++) begin
            if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1) img[y][x] = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 15) == 0) img[y][x] = 8'($urandom_range(120, 136));
            else img[y][x] = 8'd0;
         end
   endtask

   function automatic res_t model(input int nl);
      res_t r;
      longint sx, sy;
      r = '{127, 0, 127, 0, 0, 0, 0, 0};
      sx = 0;  sy = 0;
      for (int y = 0; y < nl; y++)
         for (int x = 0; x < 83; x++)
            if (img[y][x] >= 8'd128) begin
               r.cnt++;
               if (x < r.xmin) r.xmin = x;
               if (x > r.xmax) r.xmax = x;
               if (y < r.ymin) r.ymin = y;
               if (y > r.ymax) r.ymax = y;
               sx += x;  sy += y;
            end
      if (r.cnt == 0) r = '{0, 0, 0, 0, 0, 0, 0, 0};
      else begin
         r.found = (r.cnt >= 16) ? 1 : 0;
         r.cx = int'(sx / r.cnt);
         r.cy = int'(sy / r.cnt);
      end
      return r;
   endfunction

   // Raise vsync (frame end), wait a bounded number of ce cycles for the result, compare.
   task automatic frame_end_check(input string tag, input res_t e);
      int lat, exp_lat;
      exp_lat = 0;
`ifdef CENTROID_EN
      if (e.cnt != 0) exp_lat = 20;
`else
      e.cx = 0;  e.cy = 0;
`endif
      cyc(1'b0, 1'b1, 8'd0);
      lat = 0;
      while (result_valid !== 1'b1 && lat < 60) begin
         cyc(1'b0, 1'b1, 8'd0);
         lat++;
      end
      exp_results++;
      if (result_valid !== 1'b1) begin
         n_total++;  n_bad++;
         $display("FAIL %s.timeout: no result_valid after %0d ce cycles", tag, lat);
      end else begin
         check({tag, ".latency"}, lat, exp_lat);
         check({tag, ".x_min"}, int'(x_min), e.xmin);
         check({tag, ".x_max"}, int'(x_max), e.xmax);
         check({tag, ".y_min"}, int'(y_min), e.ymin);
         check({tag, ".y_max"}, int'(y_max), e.ymax);
         check({tag, ".hit_count"}, int'(hit_count), e.cnt);
         check({tag, ".blob_found"}, int'(blob_found), e.found);
         check({tag, ".cx"}, int'(cx), e.cx);
         check({tag, ".cy"}, int'(cy), e.cy);
      end
      cyc(1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      vec_t vt[6];
      int rv_before, nl;
      vt[0] = '{0, 0, 0, 0, 0, 0, 83, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
      vt[1] = '{20, 29, 10, 19, 255, 0, 83, 0, '{20, 29, 10, 19, 100, 1, 24, 14}};
      vt[2] = '{82, 82, 82, 82, 128, 127, 83, 0, '{82, 82, 82, 82, 1, 0, 82, 82}};
      vt[3] = '{20, 29, 10, 19, 255, 0, 20, 1, '{20, 29, 10, 19, 100, 1, 24, 14}};
      vt[4] = '{0, 3, 0, 3, 200, 0, 4, 0, '{0, 3, 0, 3, 16, 1, 1, 1}};
      vt[5] = '{0, 4, 0, 2, 128, 0, 3, 0, '{0, 4, 0, 2, 15, 0, 2, 1}};

      repeat (3) @(posedge clk);
      #1;
      check("rst.x_min", int'(x_min), 0);
      check("rst.x_max", int'(x_max), 0);
      check("rst.y_min", int'(y_min), 0);
      check("rst.y_max", int'(y_max), 0);
      check("rst.hit_count", int'(hit_count), 0);
      check("rst.blob_found", int'(blob_found), 0);
      check("rst.cx", int'(cx), 0);
      check("rst.cy", int'(cy), 0);
      check("rst.result_valid", int'(result_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Partial frame before the first vsync must never be published.
      fill_rect(0, 82, 0, 82, 8'd255, 8'd0);
      send_lines(10);
      cyc(1'b0, 1'b1, 8'd0);
      repeat (30) cyc(1'b0, 1'b0, 8'd0);
      check("partial_no_result", rv_count, 0);

      for (int i = 0; i < 6; i++) begin
         fill_rect(vt[i].x0, vt[i].x1, vt[i].y0, vt[i].y1, 8'(vt[i].val), 8'(vt[i].bg));
         ce_mode = vt[i].cemode;
         send_lines(vt[i].nl);
         frame_end_check($sformatf("vec%0d", i), vt[i].exp);
         ce_mode = 0;
      end

`ifdef CENTROID_EN
      fill_rect(20, 29, 10, 19, 8'd255, 8'd0);
      send_lines(20);
      rv_before = rv_count;
      cyc(1'b0, 1'b1, 8'd0);
      cyc(1'b0, 1'b0, 8'd0);
      repeat (3) cyc(1'b1, 1'b0, 8'd255);
      cyc(1'b0, 1'b0, 8'd0);
      frame_end_check("abort", '{0, 2, 0, 0, 3, 0, 1, 0});
      check("abort.one_result", rv_count - rv_before, 1);

      send_lines(20);
      cyc(1'b0, 1'b1, 8'd0);
      repeat (5) cyc(1'b0, 1'b0, 8'd0);
      #2 rst_n = 1'b0;
      #1;
      check("divrst.hit_count", int'(hit_count), 0);
      check("divrst.cx", int'(cx), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rv_before = rv_count;
      repeat (40) cyc(1'b0, 1'b0, 8'd0);
      check("divrst_no_result", rv_count - rv_before, 0);
`endif

      // Reset in the middle of a frame.
      fill_random();
      send_lines(10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.x_max", int'(x_max), 0);
      check("midrst.y_max", int'(y_max), 0);
      check("midrst.hit_count", int'(hit_count), 0);
      check("midrst.blob_found", int'(blob_found), 0);
      check("midrst.result_valid", int'(result_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rv_before = rv_count;
      send_lines(5);
      cyc(1'b0, 1'b1, 8'd0);
      repeat (40) cyc(1'b0, 1'b0, 8'd0);
      check("midrst_no_result", rv_count - rv_before, 0);
      fill_random();
      nl = $urandom_range(20, 83);
      send_lines(nl);
      frame_end_check("after_rst", model(nl));

      for (int k = 0; k < 3; k++) begin
         ce_mode = 2;
         fill_random();
         nl = $urandom_range(10, 83);
         send_lines(nl);
         frame_end_check($sformatf("rand%0d", k), model(nl));
         ce_mode = 0;
      end

      repeat (3) cyc(1'b0, 1'b0, 8'd0);
      check("rv_width", width_bad, 0);
      check("rv_total", rv_count, exp_results);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/skin_blob_stats.md
# skin_blob_stats

Per-frame statistics stage directly downstream of the 5x5 median filter in the skin-detection pipeline. Consumes the filtered 8-bit mask stream with its de/hsync/vsync framing, tracks pixel coordinates, and at each frame end publishes the bounding box and hit count of all skin pixels for the tracker/neuro classifier. An optional sequential divider adds the blob centroid.

## Interface
- H_SIZE, 83: active pixels per line; x counter range 0..H_SIZE-1.
- V_SIZE, 83: active lines per frame; y counter range 0..V_SIZE-1.
- THRESH, 128: pixel_in >= THRESH counts as a skin hit.
- MIN_COUNT, 16: minimum hits for blob_found=1.
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; all state advances only on clk edges with ce=1 (except result_valid clear).
- de_in, hsync_in, vsync_in  in  1 each  framing from median stage, active-high.
- pixel_in  in  8  filtered mask pixel.
- x_min, x_max  out  7  bounding box columns.
- y_min, y_max  out  7  bounding box rows.
- hit_count  out  13  skin pixels in frame, saturating at 8191.
- blob_found  out  1  hit_count >= MIN_COUNT.
- cx, cy  out  7  centroid (only meaningful with CENTROID_EN; 0 otherwise).
- result_valid  out  1  one-clk pulse: all result outputs updated.

## Operation
- States: WAIT_SYNC (after reset), ACCUM, DIVIDE (only with CENTROID_EN).
- WAIT_SYNC: ignore pixels until first vsync_in rising edge (partial frame discarded) -> ACCUM with accumulators cleared.
- Edge detection uses registered vsync/de sampled on ce cycles.
- x counter: increments per ce cycle with de_in=1; cleared on de_in falling edge; saturates at H_SIZE-1.
- y counter: increments on de_in falling edge; cleared at frame end; saturates at V_SIZE-1.
- Hit (de_in=1, pixel_in>=THRESH): hit_count+1 (saturating); x_min/x_max/y_min/y_max updated by compare against current (x,y). Running min init 127, max init 0.
- Frame end = vsync_in rising edge in ACCUM: snapshot stats into output registers, clear accumulators and y counter in same cycle; the pixel in that cycle (if de_in=1) belongs to the new frame.
- Zero hits: x_min=y_min=x_max=y_max=0, hit_count=0, blob_found=0, cx=cy=0; no division performed.
- Outputs hold last published values until next result_valid.

## Timing
- Reset: all outputs 0, state WAIT_SYNC, counters 0.
- Without CENTROID_EN: frame end sampled at ce-cycle T -> outputs updated and result_valid=1 on the edge ending T (visible cycle T+1).
- result_valid high exactly one clk, cleared next clk edge independent of ce.
- Pixel-to-stat latency: one ce cycle (registered compare).
- Reset mid-frame: immediate return to WAIT_SYNC; in-progress frame and divider discarded, no result_valid.

## Configuration
- CENTROID_EN defined: 20-bit sum_x/sum_y accumulators; at frame end operands snapshot, state DIVIDE runs two parallel restoring dividers (sum/hit_count), one bit per ce cycle, 20 ce cycles; all outputs including cx, cy published together with result_valid on the 21st ce cycle after frame end. ACCUM continues for the new frame during DIVIDE. A new frame end during DIVIDE aborts the division, drops that result, restarts with the new snapshot. Zero hits skip division (publish at T+1).
- Not defined: no sum accumulators or divider; cx=cy=0 constant; DIVIDE state absent.

## Test plan
- Reset, one partial frame then vsync then 83x83 frame all pixel_in=0 -> first result after second vsync: hit_count=0, bbox all 0, blob_found=0; no result for partial frame.
- Frame with pixel_in=255 on rows 10..19, cols 20..29 -> x_min=20, x_max=29, y_min=10, y_max=19, hit_count=100, blob_found=1; with CENTROID_EN cx=24, cy=14 after 21 ce cycles.
- Single hit at (82,82), pixel_in=128; neighbours 127 -> bbox 82/82/82/82, hit_count=1, blob_found=0.
- ce toggled 1/0 every clk over the rectangle frame -> identical results to ce=1 run; result_valid still exactly one clk wide.
- CENTROID_EN: two vsync edges 5 ce cycles apart during DIVIDE -> only second frame's result published, one result_valid.
- rst_n asserted mid-frame and mid-DIVIDE -> outputs 0 immediately, no result_valid until a full frame after next vsync.
